// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared CSR addresses, cause codes, write modes and FSM states for the trap controller
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam logic [31:0] CAUSE_ILLEGAL     = 32'd2;
   localparam logic [31:0] CAUSE_LOAD_FAULT  = 32'd5;
   localparam logic [31:0] CAUSE_STORE_FAULT = 32'd7;
   localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   localparam logic [1:0] WSC_NONE  = 2'b00;
   localparam logic [1:0] WSC_WRITE = 2'b01;
   localparam logic [1:0] WSC_SET   = 2'b10;
   localparam logic [1:0] WSC_CLEAR = 2'b11;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } trap_state_t;

   function automatic logic [31:0] csr_apply(input logic [1:0]  mode,
                                             input logic [31:0] old_val,
                                             input logic [31:0] wdata);
      case (mode)
         WSC_SET:   return old_val | wdata;
         WSC_CLEAR: return old_val & ~wdata;
         default:   return wdata;
      endcase
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder over the pending interrupt lines
module irq_prio_enc #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   output logic               valid,
   output logic [3:0]         idx
);

   // Scanning downwards lets the lowest set index overwrite any higher one.
   always_comb begin
      valid = |req;
      idx   = 4'd0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) idx = 4'(i);
      end
   end

endmodule

// File: rtl/trap_ctrl_mc.sv
// rtl/trap_ctrl_mc.sv - machine-mode trap controller: trap CSRs, exception/interrupt priority, flush and redirect FSM
module trap_ctrl_mc
   import trap_pkg::*;
#(
   parameter int          NUM_IRQ      = 4,
   parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
   parameter int          HAS_VECTORED = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               csr_rw_in,
   input  logic [1:0]         csr_wsc_mode_in,
   input  logic               csr_w_imm_mux,
   input  logic [11:0]        csr_rw_addr_in,
   input  logic [31:0]        csr_w_data_reg,
   input  logic [4:0]         csr_w_data_imm,
   output logic [31:0]        csr_r_data_out,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               mem_valid,
   input  logic               illegal_inst,
   input  logic               l_access_fault,
   input  logic               s_access_fault,
   input  logic               ecall_m,
   input  logic [31:0]        bad_addr,
   input  logic [31:0]        bad_inst,
   input  logic               mret,
   input  logic [31:0]        epc_cur,
   input  logic [31:0]        epc_next,
   output logic [31:0]        PC_redirect,
   output logic               redirect_mux,
   output logic               reg_FD_flush,
   output logic               reg_DE_flush,
   output logic               reg_EM_flush,
   output logic               reg_MW_flush,
   output logic               RegWrite_cancel,
   output logic               busy
);

   trap_state_t        state;
   logic               mst_mie;
   logic               mst_mpie;
   logic [NUM_IRQ-1:0] mie_q;
   logic [NUM_IRQ-1:0] mip_q;
   logic [31:0]        mtvec_q;
   logic [31:0]        mepc_q;
   logic [31:0]        mcause_q;
   logic [31:0]        mtval_q;
   logic [31:0]        target_q;

   logic [NUM_IRQ-1:0] irq_pend;
   logic               irq_any;
   logic [3:0]         irq_idx;

   logic [31:0] mstatus_rd;
   logic [31:0] mie_rd;
   logic [31:0] mip_rd;
   logic [31:0] csr_wdata;
   logic [31:0] csr_new;

   logic        in_idle;
   logic        exc;
   logic        intr;
   logic        trap;
   logic        do_mret;
   logic        csr_we;
   logic [31:0] trap_cause;
   logic [31:0] trap_tval;
   logic [31:0] trap_epc;
   logic [31:0] trap_target;
   logic [31:0] mtvec_base;

   function automatic logic [31:0] mtvec_legal(input logic [31:0] v);
      logic [31:0] r;
      r    = v;
      r[1] = 1'b0;
      if (HAS_VECTORED == 0) r[0] = 1'b0;
      return r;
   endfunction

   assign irq_pend = mip_q & mie_q;

   irq_prio_enc #(
      .NUM_REQ (NUM_IRQ)
   ) u_irq_prio_enc (
      .req   (irq_pend),
      .valid (irq_any),
      .idx   (irq_idx)
   );

   always_comb begin
      mstatus_rd               = 32'd0;
      mstatus_rd[MSTATUS_MIE]  = mst_mie;
      mstatus_rd[MSTATUS_MPIE] = mst_mpie;
      mie_rd                   = 32'd0;
      mie_rd[16 +: NUM_IRQ]    = mie_q;
      mip_rd                   = 32'd0;
      mip_rd[16 +: NUM_IRQ]    = mip_q;
      case (csr_rw_addr_in)
         CSR_MSTATUS: csr_r_data_out = mstatus_rd;
         CSR_MIE:     csr_r_data_out = mie_rd;
         CSR_MTVEC:   csr_r_data_out = mtvec_q;
         CSR_MEPC:    csr_r_data_out = mepc_q;
         CSR_MCAUSE:  csr_r_data_out = mcause_q;
         CSR_MTVAL:   csr_r_data_out = mtval_q;
         CSR_MIP:     csr_r_data_out = mip_rd;
         default:     csr_r_data_out = 32'd0;
      endcase
   end

   assign csr_wdata = csr_w_imm_mux ? {27'd0, csr_w_data_imm} : csr_w_data_reg;
   assign csr_new   = csr_apply(csr_wsc_mode_in, csr_r_data_out, csr_wdata);

   assign in_idle = (state == ST_IDLE);
   assign exc     = mem_valid & (illegal_inst | l_access_fault | s_access_fault | ecall_m);
   assign intr    = mem_valid & mst_mie & irq_any;
   assign trap    = in_idle & (exc | intr);
   assign do_mret = in_idle & mret & ~trap;
   assign csr_we  = in_idle & csr_rw_in & (csr_wsc_mode_in != WSC_NONE) & ~trap;

   always_comb begin
      trap_cause = {27'd0, 1'b1, irq_idx} | 32'h8000_0000;
      trap_tval  = 32'd0;
      trap_epc   = epc_next;
      if (illegal_inst) begin
         trap_cause = CAUSE_ILLEGAL;
         trap_tval  = bad_inst;
      end else if (l_access_fault) begin
         trap_cause = CAUSE_LOAD_FAULT;
         trap_tval  = bad_addr;
      end else if (s_access_fault) begin
         trap_cause = CAUSE_STORE_FAULT;
         trap_tval  = bad_addr;
      end else if (ecall_m) begin
         trap_cause = CAUSE_ECALL_M;
      end
      if (exc) trap_epc = epc_cur;
   end

   // Only interrupts are vectored; exceptions always enter at the base.
   assign mtvec_base  = {mtvec_q[31:2], 2'b00};
   assign trap_target = (mtvec_q[0] && !exc)
                      ? mtvec_base + {25'd0, trap_cause[4:0], 2'b00}
                      : mtvec_base;

   assign redirect_mux    = (state == ST_REDIRECT);
   assign busy            = (state == ST_REDIRECT);
   assign PC_redirect     = target_q;
   assign reg_FD_flush    = trap | do_mret | redirect_mux;
   assign reg_DE_flush    = trap | do_mret | redirect_mux;
   assign reg_EM_flush    = trap | do_mret;
   assign reg_MW_flush    = trap;
   assign RegWrite_cancel = trap & exc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         mst_mie  <= 1'b0;
         mst_mpie <= 1'b0;
         mie_q    <= '0;
         mip_q    <= '0;
         mtvec_q  <= mtvec_legal(MTVEC_RESET);
         mepc_q   <= 32'd0;
         mcause_q <= 32'd0;
         mtval_q  <= 32'd0;
         target_q <= 32'd0;
      end else begin
         mip_q <= irq;
         case (state)
            ST_IDLE: begin
               if (trap) begin
                  mepc_q   <= trap_epc & 32'hFFFF_FFFC;
                  mcause_q <= trap_cause;
                  mtval_q  <= trap_tval;
                  mst_mpie <= mst_mie;
                  mst_mie  <= 1'b0;
                  target_q <= trap_target;
                  state    <= ST_REDIRECT;
               end else begin
                  if (csr_we) begin
                     case (csr_rw_addr_in)
                        CSR_MSTATUS: begin
                           mst_mie  <= csr_new[MSTATUS_MIE];
                           mst_mpie <= csr_new[MSTATUS_MPIE];
                        end
                        CSR_MIE:    mie_q    <= csr_new[16 +: NUM_IRQ];
                        CSR_MTVEC:  mtvec_q  <= mtvec_legal(csr_new);
                        CSR_MEPC:   mepc_q   <= csr_new & 32'hFFFF_FFFC;
                        CSR_MCAUSE: mcause_q <= csr_new;
                        CSR_MTVAL:  mtval_q  <= csr_new;
                        default: ;
                     endcase
                  end
                  // mret comes after the CSR write so its mstatus update wins.
                  if (do_mret) begin
                     mst_mie  <= mst_mpie;
                     mst_mpie <= 1'b1;
                     target_q <= mepc_q;
                     state    <= ST_REDIRECT;
                  end
               end
            end
            ST_REDIRECT: begin
               target_q <= 32'd0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_ctrl_mc.sv
// tb/tb_trap_ctrl_mc.sv - directed scoreboard bench for trap_ctrl_mc
module tb_trap_ctrl_mc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        csr_rw_in = 1'b0;
   logic [1:0]  csr_wsc_mode_in = 2'b00;
   logic        csr_w_imm_mux = 1'b0;
   logic [11:0] csr_rw_addr_in = 12'h000;
   logic [31:0] csr_w_data_reg = 32'd0;
   logic [4:0]  csr_w_data_imm = 5'd0;
   logic [31:0] csr_r_data_out;
   logic [3:0]  irq = 4'b0000;
   logic        mem_valid = 1'b0;
   logic        illegal_inst = 1'b0;
   logic        l_access_fault = 1'b0;
   logic        s_access_fault = 1'b0;
   logic        ecall_m = 1'b0;
   logic [31:0] bad_addr = 32'd0;
   logic [31:0] bad_inst = 32'd0;
   logic        mret = 1'b0;
   logic [31:0] epc_cur = 32'd0;
   logic [31:0] epc_next = 32'd0;
   logic [31:0] PC_redirect;
   logic        redirect_mux;
   logic        reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush;
   logic        RegWrite_cancel;
   logic        busy;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb[$];

   trap_ctrl_mc #(
      .NUM_IRQ      (4),
      .MTVEC_RESET  (32'h0000_0080),
      .HAS_VECTORED (1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .csr_rw_in       (csr_rw_in),
      .csr_wsc_mode_in (csr_wsc_mode_in),
      .csr_w_imm_mux   (csr_w_imm_mux),
      .csr_rw_addr_in  (csr_rw_addr_in),
      .csr_w_data_reg  (csr_w_data_reg),
      .csr_w_data_imm  (csr_w_data_imm),
      .csr_r_data_out  (csr_r_data_out),
      .irq             (irq),
      .mem_valid       (mem_valid),
      .illegal_inst    (illegal_inst),
      .l_access_fault  (l_access_fault),
      .s_access_fault  (s_access_fault),
      .ecall_m         (ecall_m),
      .bad_addr        (bad_addr),
      .bad_inst        (bad_inst),
      .mret            (mret),
      .epc_cur         (epc_cur),
      .epc_next        (epc_next),
      .PC_redirect     (PC_redirect),
      .redirect_mux    (redirect_mux),
      .reg_FD_flush    (reg_FD_flush),
      .reg_DE_flush    (reg_DE_flush),
      .reg_EM_flush    (reg_EM_flush),
      .reg_MW_flush    (reg_MW_flush),
      .RegWrite_cancel (RegWrite_cancel),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Every redirect the DUT shows must match the oldest expected target.
   always @(negedge clk) begin
      if (!rst && redirect_mux) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_redirect: got PC_redirect=%h, want no redirect", PC_redirect);
         end else begin
            chk("redirect_pc", PC_redirect, sb.pop_front());
            chk("redirect_flags", 32'({busy, reg_FD_flush, reg_DE_flush, reg_EM_flush}), 32'hE);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem;
      {illegal_inst, l_access_fault, s_access_fault, ecall_m} = 4'b0000;
      mem_valid       = 1'b0;
      mret            = 1'b0;
      csr_rw_in       = 1'b0;
      csr_wsc_mode_in = 2'b00;
      csr_w_imm_mux   = 1'b0;
   endtask

   task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
      csr_rw_addr_in = a;
      #1;
      chk(name, csr_r_data_out, exp);
   endtask

   task automatic csr_op(input logic [11:0] a, input logic [1:0] m, input logic imm_sel,
                         input logic [31:0] rv, input logic [4:0] iv);
      csr_rw_in       = 1'b1;
      csr_wsc_mode_in = m;
      csr_w_imm_mux   = imm_sel;
      csr_rw_addr_in  = a;
      csr_w_data_reg  = rv;
      csr_w_data_imm  = iv;
      tick;
      clear_mem;
   endtask

   task automatic take_trap(input logic [3:0] flags, input logic [31:0] cur, input logic [31:0] nxt,
                            input logic [31:0] binst, input logic [31:0] baddr,
                            input logic [31:0] exp_tgt, input logic exp_cancel);
      {illegal_inst, l_access_fault, s_access_fault, ecall_m} = flags;
      mem_valid = 1'b1;
      epc_cur   = cur;
      epc_next  = nxt;
      bad_inst  = binst;
      bad_addr  = baddr;
      sb.push_back(exp_tgt);
      #1;
      chk("trap_flushes", 32'({reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush}), 32'hF);
      chk("trap_cancel", 32'(RegWrite_cancel), 32'(exp_cancel));
      chk("trap_no_early_redirect", 32'(redirect_mux), 32'd0);
      tick;
      clear_mem;
      tick;
   endtask

   task automatic do_mret(input logic [31:0] exp_tgt);
      mret      = 1'b1;
      mem_valid = 1'b1;
      sb.push_back(exp_tgt);
      tick;
      clear_mem;
      tick;
   endtask

   initial begin
      tick;
      tick;
      rst = 1'b0;
      rd("reset_mtvec", 12'h305, 32'h0000_0080);
      rd("reset_mstatus", 12'h300, 32'd0);
      rd("reset_mip", 12'h344, 32'd0);
      chk("reset_outputs", 32'({redirect_mux, busy, reg_FD_flush, reg_DE_flush,
                                reg_EM_flush, reg_MW_flush, RegWrite_cancel}), 32'd0);

      csr_op(12'h305, 2'b01, 1'b0, 32'h0000_0100, 5'd0);
      rd("mtvec_write", 12'h305, 32'h0000_0100);

      take_trap(4'b1000, 32'h40, 32'h44, 32'hFFFF_FFFF, 32'd0, 32'h100, 1'b1);
      rd("illegal_mcause", 12'h342, 32'd2);
      rd("illegal_mepc", 12'h341, 32'h40);
      rd("illegal_mtval", 12'h343, 32'hFFFF_FFFF);
      rd("illegal_mstatus", 12'h300, 32'd0);

      take_trap(4'b0110, 32'h50, 32'h54, 32'd0, 32'hDEAD_BEE0, 32'h100, 1'b1);
      rd("lfault_mcause", 12'h342, 32'd5);
      rd("lfault_mtval", 12'h343, 32'hDEAD_BEE0);

      csr_op(12'h300, 2'b01, 1'b0, 32'h0000_0008, 5'd0);
      csr_op(12'h304, 2'b01, 1'b0, 32'h0005_0000, 5'd0);
      csr_op(12'h305, 2'b01, 1'b0, 32'h0000_0201, 5'd0);
      irq = 4'b0101;
      tick;
      rd("mip_latched", 12'h344, 32'h0005_0000);
      rd("mie_write", 12'h304, 32'h0005_0000);
      rd("mstatus_mie_set", 12'h300, 32'h8);

      take_trap(4'b0000, 32'h84, 32'h88, 32'd0, 32'd0, 32'h240, 1'b0);
      rd("irq0_mcause", 12'h342, 32'h8000_0010);
      rd("irq0_mepc", 12'h341, 32'h88);
      rd("irq0_mtval", 12'h343, 32'd0);
      rd("irq0_mstatus", 12'h300, 32'h80);

      do_mret(32'h88);
      rd("mret_mstatus", 12'h300, 32'h88);

      take_trap(4'b0001, 32'h300, 32'h304, 32'd0, 32'd0, 32'h200, 1'b1);
      rd("ecall_mcause", 12'h342, 32'd11);
      rd("ecall_mepc", 12'h341, 32'h300);
      rd("ecall_mstatus", 12'h300, 32'h80);

      do_mret(32'h300);
      take_trap(4'b0000, 32'h300, 32'h304, 32'd0, 32'd0, 32'h240, 1'b0);
      rd("post_mret_irq_mcause", 12'h342, 32'h8000_0010);
      rd("post_mret_irq_mepc", 12'h341, 32'h304);

      do_mret(32'h304);
      irq = 4'b0110;
      tick;
      take_trap(4'b0000, 32'h304, 32'h308, 32'd0, 32'd0, 32'h248, 1'b0);
      rd("irq2_mcause", 12'h342, 32'h8000_0012);
      rd("irq2_mepc", 12'h341, 32'h308);

      // Trap with a same-cycle CSR write, then held through REDIRECT with another write.
      illegal_inst    = 1'b1;
      mem_valid       = 1'b1;
      epc_cur         = 32'h500;
      bad_inst        = 32'h1111;
      csr_rw_in       = 1'b1;
      csr_wsc_mode_in = 2'b01;
      csr_rw_addr_in  = 12'h305;
      csr_w_data_reg  = 32'h999;
      sb.push_back(32'h200);
      tick;
      epc_cur         = 32'h600;
      bad_inst        = 32'h2222;
      csr_rw_addr_in  = 12'h343;
      csr_w_data_reg  = 32'hDEAD;
      tick;
      clear_mem;
      tick;
      rd("dropped_mtvec", 12'h305, 32'h201);
      rd("held_mepc", 12'h341, 32'h500);
      rd("held_mtval", 12'h343, 32'h1111);

      csr_op(12'h305, 2'b10, 1'b1, 32'd0, 5'b00011);
      rd("mtvec_set_imm", 12'h305, 32'h201);
      csr_op(12'h305, 2'b11, 1'b0, 32'h1, 5'd0);
      rd("mtvec_clear", 12'h305, 32'h200);
      csr_op(12'h305, 2'b10, 1'b0, 32'h4, 5'd0);
      rd("mtvec_set_reg", 12'h305, 32'h204);
      csr_op(12'h305, 2'b00, 1'b0, 32'h777, 5'd0);
      rd("mode00_nowrite", 12'h305, 32'h204);
      csr_op(12'h341, 2'b01, 1'b0, 32'h123, 5'd0);
      rd("mepc_align", 12'h341, 32'h120);
      csr_op(12'h344, 2'b10, 1'b0, 32'hFFFF_FFFF, 5'd0);
      rd("mip_readonly", 12'h344, 32'h0006_0000);
      csr_op(12'h340, 2'b01, 1'b0, 32'h55, 5'd0);
      rd("unimpl_zero", 12'h340, 32'd0);

      irq = 4'b0000;
      csr_op(12'h305, 2'b01, 1'b0, 32'h400, 5'd0);
      illegal_inst = 1'b1;
      mem_valid    = 1'b1;
      tick;
      rst = 1'b1;
      clear_mem;
      tick;
      rst = 1'b0;
      #1;
      chk("rst_redirect_outputs", 32'({redirect_mux, busy, reg_FD_flush, reg_DE_flush,
                                       reg_EM_flush, reg_MW_flush, RegWrite_cancel}), 32'd0);
      chk("rst_redirect_pc", PC_redirect, 32'd0);
      rd("rst_redirect_mtvec", 12'h305, 32'h80);
      rd("rst_redirect_mcause", 12'h342, 32'd0);

      tick;
      tick;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
